score_event_gen: RTL

Game-side producer of score events for the 8x8 Flappy Bird datapath. It watches the bird row and the moving pipe (column, gap row) and runs the game-state machine (READY/PLAY/OVER). It emits stretched, well-separated `detect_score` pulses that are safe to use as the count edge of the downstream score counter, and it flags collisions as `game_over`.

---
 rtl/flappy_pkg.sv | 9 +
 rtl/score_pulse_stretch.sv | 94 +++++++++
 rtl/score_event_gen.sv | 95 +++++++++
 3 files changed

// File: rtl/flappy_pkg.sv
// Shared types and constants for the 8x8 Flappy Bird datapath.
package flappy_pkg;

  localparam int unsigned BOARD_DIM = 8;

  typedef enum logic [1:0] {READY, PLAY, OVER} game_state_t;
  typedef enum logic [1:0] {IDLE, HIGH, GAP} pulse_state_t;

endpackage

// File: rtl/score_pulse_stretch.sv
// Queues score events and replays them as PULSE_LEN-wide pulses with an
// equally long low gap between consecutive pulses.
module score_pulse_stretch
  import flappy_pkg::*;
#(
  parameter int unsigned PULSE_LEN = 4,
  parameter int unsigned PEND_MAX  = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic event_in,
  input  logic clear,
  output logic detect_score
);

  localparam int unsigned PW = $clog2(PEND_MAX + 1);
  localparam logic [PW-1:0] PEND_TOP = PW'(PEND_MAX);
  localparam logic [3:0] CNT_LAST = 4'(PULSE_LEN - 1);

  pulse_state_t  state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [PW-1:0] pend_q, pend_d;
  logic          det_q;
  logic          dec;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dec     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pend_q != '0) begin
          state_d = HIGH;
          cnt_d   = '0;
          dec     = 1'b1;
        end
      end
      HIGH: begin
        if (cnt_q == CNT_LAST) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      GAP: begin
        // Go straight to the next pulse so rising edges stay 2*PULSE_LEN apart.
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (pend_q != '0) begin
            state_d = HIGH;
            dec     = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    pend_d = pend_q;
    if (clear) begin
      pend_d = '0;
    end else if (event_in && !dec && (pend_q != PEND_TOP)) begin
      pend_d = pend_q + 1'b1;
    end else if (dec && !event_in) begin
      pend_d = pend_q - 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      det_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      det_q   <= (state_d == HIGH);
    end
  end

  assign detect_score = det_q;

endmodule

// File: rtl/score_event_gen.sv
// Game FSM, pipe-gap comparator and pass detection feeding the score pulse
// stretcher; flags collisions as game_over.
module score_event_gen
  import flappy_pkg::*;
#(
  parameter logic [2:0]  BIRD_COL  = 3'd1,
  parameter int unsigned GAP_H     = 3,
  parameter int unsigned PULSE_LEN = 4,
  parameter int unsigned PEND_MAX  = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       pipe_step,
  input  logic [2:0] pipe_col,
  input  logic [2:0] gap_row,
  input  logic [2:0] bird_row,
  output logic       detect_score,
  output logic       game_over,
  output logic       playing
);

  game_state_t gs_q, gs_d;
  logic        armed_q, armed_d;
  logic        game_over_q, playing_q;
  logic        pass, clear;
  logic [3:0]  gap_top;
  logic        in_gap, at_col;

  // 4-bit top avoids wrap; rows above the board simply never match.
  assign gap_top = {1'b0, gap_row} + 4'(GAP_H);
  assign in_gap  = (bird_row >= gap_row) && ({1'b0, bird_row} < gap_top);
  assign at_col  = (pipe_col == BIRD_COL);

  always_comb begin
    gs_d    = gs_q;
    armed_d = armed_q;
    pass    = 1'b0;
    clear   = 1'b0;
    unique case (gs_q)
      READY, OVER: begin
        if (start) begin
          gs_d    = PLAY;
          armed_d = 1'b0;
          clear   = 1'b1;
        end
      end
      PLAY: begin
        if (pipe_step) begin
          if (at_col) begin
            if (in_gap) begin
              armed_d = 1'b1;
            end else begin
              gs_d    = OVER;
              armed_d = 1'b0;
            end
          end else if (armed_q) begin
            pass    = 1'b1;
            armed_d = 1'b0;
          end
        end
      end
      default: gs_d = READY;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gs_q        <= READY;
      armed_q     <= 1'b0;
      game_over_q <= 1'b0;
      playing_q   <= 1'b0;
    end else begin
      gs_q        <= gs_d;
      armed_q     <= armed_d;
      game_over_q <= (gs_d == OVER);
      playing_q   <= (gs_d == PLAY);
    end
  end

  assign game_over = game_over_q;
  assign playing   = playing_q;

  score_pulse_stretch #(
    .PULSE_LEN(PULSE_LEN),
    .PEND_MAX (PEND_MAX)
  ) u_stretch (
    .clock       (clock),
    .reset       (reset),
    .event_in    (pass),
    .clear       (clear),
    .detect_score(detect_score)
  );

endmodule
